elevator_controller: RTL and testbench

- Request scheduler that sits directly upstream of the elevator car model.
- Latches floor requests and chooses a direction using SCAN: keep going the current way while requests remain there, otherwise reverse.
- Drives the car's 2-bit command bus (00 idle, 01 up, 10 down, 11 serve).
- Consumes the car's cur_floor, doors_open and served_pulse, and clears each request once it has been served.

---
 rtl/elevator_controller.sv | 161 ++++++++++++++++
 tb/tb_elevator_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
// SCAN request scheduler driving the car command bus (00 idle, 01 up, 10 down, 11 serve).
// Optional move watchdog: define ELEV_CTRL_WATCHDOG_EN.
module elevator_controller #(
  parameter int N_FLOORS    = 4,
  parameter int FLOOR_BITS  = $clog2(N_FLOORS),
  parameter int WDOG_CYCLES = 200
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  input  logic [FLOOR_BITS-1:0] i_req_floor,
  input  logic [FLOOR_BITS-1:0] i_cur_floor,
  input  logic                  i_doors_open,
  input  logic                  i_served_pulse,
  output logic [1:0]            o_command,
  output logic [N_FLOORS-1:0]   o_pending,
  output logic                  o_dir_up,
  output logic                  o_busy,
  output logic                  o_fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_SERVE, S_DOOR_WAIT
  } state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_command, w_cmd_next;
  logic [N_FLOORS-1:0]   r_pending;
  logic                  r_dir_up, w_dir_next;
  logic [FLOOR_BITS-1:0] r_start_floor;

  logic [N_FLOORS-1:0] w_mask_above, w_mask_below, w_cur_onehot, w_set, w_clr;
  logic w_any_above, w_any_below, w_here, w_arrived, w_moving, w_latch;
  logic w_wdog_hit, w_fault;

  // Floor-relative masks; an out-of-range cur_floor simply matches no bit.
  always_comb begin
    w_mask_above = '0;
    w_mask_below = '0;
    w_cur_onehot = '0;
    w_set        = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      w_mask_above[f] = (f > int'(i_cur_floor));
      w_mask_below[f] = (f < int'(i_cur_floor));
      w_cur_onehot[f] = (f == int'(i_cur_floor));
      w_set[f]        = i_req_valid && (f == int'(i_req_floor));
    end
  end

  assign w_any_above = |(r_pending & w_mask_above);
  assign w_any_below = |(r_pending & w_mask_below);
  assign w_here      = |(r_pending & w_cur_onehot);
  assign w_arrived   = (i_cur_floor != r_start_floor);
  assign w_moving    = (r_state == S_MOVE_UP) || (r_state == S_MOVE_DOWN);

  always_comb begin
    w_next     = r_state;
    w_dir_next = r_dir_up;
    w_latch    = 1'b0;
    w_clr      = '0;
    case (r_state)
      S_IDLE: begin
        if (!w_fault && (|r_pending)) begin
          if (w_here) begin
            w_next = S_SERVE;
          end else begin
            // Keep heading the current way if it has work, else reverse.
            w_latch = 1'b1;
            if (r_dir_up ? w_any_above : !w_any_below) begin
              w_next     = S_MOVE_UP;
              w_dir_next = 1'b1;
            end else begin
              w_next     = S_MOVE_DOWN;
              w_dir_next = 1'b0;
            end
          end
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (w_arrived) begin
          if (w_here)
            w_next = S_SERVE;
          else if ((r_state == S_MOVE_UP) ? w_any_above : w_any_below)
            w_latch = 1'b1;
          else
            w_next = S_IDLE;
        end else if (w_wdog_hit) begin
          w_next = S_IDLE;
        end
      end
      S_SERVE: begin
        if (i_served_pulse) begin
          w_clr  = w_cur_onehot;
          w_next = S_DOOR_WAIT;
        end
      end
      S_DOOR_WAIT: begin
        if (!i_doors_open && !i_served_pulse) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_next = 2'b00;
    case (w_next)
      S_MOVE_UP:   w_cmd_next = 2'b01;
      S_MOVE_DOWN: w_cmd_next = 2'b10;
      S_SERVE:     w_cmd_next = 2'b11;
      default:     w_cmd_next = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_command     <= 2'b00;
      r_pending     <= '0;
      r_dir_up      <= 1'b1;
      r_start_floor <= '0;
    end else begin
      r_state   <= w_next;
      r_command <= w_cmd_next;
      r_dir_up  <= w_dir_next;
      r_pending <= (r_pending | w_set) & ~w_clr;  // clear beats a same-cycle set
      if (w_latch) r_start_floor <= i_cur_floor;
    end
  end

`ifdef ELEV_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_fault;

  assign w_wdog_hit = (r_wdog == WD_W'(WDOG_CYCLES - 1));
  assign w_fault    = r_fault;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdog  <= '0;
      r_fault <= 1'b0;
    end else if (w_latch) begin
      r_wdog <= '0;
    end else if (w_moving && !w_arrived) begin
      if (w_wdog_hit) r_fault <= 1'b1;
      else            r_wdog  <= r_wdog + WD_W'(1);
    end
  end
`else
  assign w_wdog_hit = 1'b0;
  assign w_fault    = 1'b0;
`endif

  assign o_command = r_command;
  assign o_pending = r_pending;
  assign o_dir_up  = r_dir_up;
  assign o_busy    = (r_state != S_IDLE);
  assign o_fault   = w_fault;

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: directed scenarios plus a random car, checked
// every cycle against a floor-array SCAN reference model.
module tb_elevator_controller;
  localparam int N  = 5;
  localparam int FB = $clog2(N);
  localparam int WD = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [FB-1:0] req_floor = '0;
  logic [FB-1:0] cur_floor = '0;
  logic          doors_open = 1'b0;
  logic          served_pulse = 1'b0;
  logic [1:0]    command;
  logic [N-1:0]  pending;
  logic          dir_up, busy, fault;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  elevator_controller #(.N_FLOORS(N), .FLOOR_BITS(FB), .WDOG_CYCLES(WD)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_floor(req_floor),
    .i_cur_floor(cur_floor), .i_doors_open(doors_open), .i_served_pulse(served_pulse),
    .o_command(command), .o_pending(pending), .o_dir_up(dir_up), .o_busy(busy),
    .o_fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 travelling (direction m_up), 2 serving, 3 doors closing.
  bit m_pend[N];
  int m_phase = 0;
  bit m_up = 1'b1;
  int m_start = 0;
  bit m_fault = 1'b0;
  int m_wd = 0;

  function automatic bit any_side(input bit up, input int f);
    for (int i = 0; i < N; i++)
      if (m_pend[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_cmd();
    case (m_phase)
      1:       return m_up ? 2'b01 : 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step();
    int  cur, clr;
    bit  above, below, anyp;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_phase = 0; m_up = 1'b1; m_start = 0; m_fault = 1'b0; m_wd = 0;
      return;
    end
    cur   = int'(cur_floor);
    clr   = -1;
    above = any_side(1'b1, cur);
    below = any_side(1'b0, cur);
    anyp  = 1'b0;
    foreach (m_pend[i]) anyp |= m_pend[i];
    case (m_phase)
      0: if (!m_fault && anyp) begin
        if (m_pend[cur]) m_phase = 2;
        else begin
          m_up = m_up ? above : !below;
          m_phase = 1; m_start = cur; m_wd = 0;
        end
      end
      1: if (cur != m_start) begin
        if (m_pend[cur]) m_phase = 2;
        else if (m_up ? above : below) begin m_start = cur; m_wd = 0; end
        else m_phase = 0;
      end
`ifdef ELEV_CTRL_WATCHDOG_EN
      else if (m_wd == WD - 1) begin m_fault = 1'b1; m_phase = 0; end
      else m_wd++;
`endif
      2: if (served_pulse) begin clr = cur; m_phase = 3; end
      3: if (!doors_open && !served_pulse) m_phase = 0;
      default: m_phase = 0;
    endcase
    if (req_valid && int'(req_floor) < N) m_pend[int'(req_floor)] = 1'b1;
    if (clr >= 0) m_pend[clr] = 1'b0;
  endtask

  task automatic compare_all();
    logic [N-1:0] mp;
    for (int i = 0; i < N; i++) mp[i] = m_pend[i];
    chk("cmd", command, m_cmd());
    chk("pending", pending, mp);
    chk("dir_up", dir_up, m_up);
    chk("busy", busy, m_phase != 0);
    chk("fault", fault, m_fault);
  endtask

  // Car model: moves on 01/10 after a random delay, opens doors and pulses served on 11.
  bit car_auto = 1'b0;
  bit chaos    = 1'b0;
  int mv_t = 0, sv_t = 0, cl_t = 0;
  bit sv_done = 1'b0;
  bit saw_up = 1'b0, saw_dn = 1'b0;

  task automatic car_reset();
    doors_open = 1'b0; served_pulse = 1'b0; sv_done = 1'b0; mv_t = 0; sv_t = 0; cl_t = 0;
  endtask

  task automatic car_update();
    if (command == 2'b01 || command == 2'b10) begin
      if (mv_t == 0) begin
        if (command == 2'b01) begin
          chk("top_bound", int'(cur_floor) < N - 1, 1);
          if (int'(cur_floor) < N - 1) cur_floor = cur_floor + 1'b1;
        end else begin
          chk("bottom_bound", cur_floor != '0, 1);
          if (cur_floor != '0) cur_floor = cur_floor - 1'b1;
        end
        mv_t = $urandom_range(1, 3);
      end else mv_t--;
    end
    if (command == 2'b11) begin
      if (!doors_open) begin doors_open = 1'b1; sv_t = $urandom_range(0, 2); sv_done = 1'b0; end
      else if (sv_t > 0) sv_t--;
      else if (!sv_done) begin served_pulse = 1'b1; sv_done = 1'b1; cl_t = $urandom_range(0, 3); end
    end else if (doors_open) begin
      if (cl_t == 0) begin doors_open = 1'b0; sv_done = 1'b0; end
      else cl_t--;
    end else if (chaos && $urandom_range(0, 15) == 0) begin
      served_pulse = 1'b1;  // stray pulse outside SERVE must be ignored
    end
    if (chaos && $urandom_range(0, 3) == 0) begin
      req_valid = 1'b1;
      req_floor = FB'($urandom_range(0, 7));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (command == 2'b01) saw_up = 1'b1;
    if (command == 2'b10) saw_dn = 1'b1;
    req_valid    = 1'b0;
    served_pulse = 1'b0;
    if (car_auto) car_update();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; car_reset();
  endtask

  task automatic wait_cmd(input logic [1:0] c, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (command == c) ok = 1'b1;
      else tick();
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!busy && pending == '0) ok = 1'b1;
      else tick();
    end
    chk(tag, ok, 1);
  endtask

  task automatic req(input int f);
    req_valid = 1'b1; req_floor = FB'(f); tick();
  endtask

  initial begin
    // reset state
    tick(); rst = 1'b0;
    chk("rst_cmd", command, 0); chk("rst_pend", pending, 0);
    chk("rst_dir", dir_up, 1); chk("rst_busy", busy, 0); chk("rst_fault", fault, 0);

    // single request two floors up, manual car
    cur_floor = '0;
    req(2);
    chk("t1_pend", pending, 5'b00100); chk("t1_cmd_lat", command, 0);
    tick(); chk("t1_up", command, 2'b01);
    cur_floor = 1; tick(); tick(); chk("t1_hold", command, 2'b01);
    cur_floor = 2; tick(); chk("t1_serve", command, 2'b11);
    doors_open = 1'b1; tick();
    served_pulse = 1'b1; tick();
    chk("t1_clr", pending, 0); chk("t1_dw_cmd", command, 0); chk("t1_dw_busy", busy, 1);
    doors_open = 1'b0; tick(); chk("t1_idle", busy, 0);

    // SCAN order: floor 1 before 3 on the way up
    do_reset(); cur_floor = '0;
    req(3); req(1);
    car_auto = 1'b1;
    wait_cmd(2'b11, "t2_wait1");
    chk("t2_first", cur_floor, 1); chk("t2_dir", dir_up, 1);
    for (int i = 0; i < 100 && command == 2'b11; i++) tick();
    wait_cmd(2'b11, "t2_wait3");
    chk("t2_second", cur_floor, 3); chk("t2_dir2", dir_up, 1);
    wait_idle("t2_idle");

    // reversal from floor 2 toward floor 0
    car_auto = 1'b0; cur_floor = 2; do_reset();
    req(0);
    saw_up = 1'b0;
    car_auto = 1'b1;
    wait_cmd(2'b10, "t3_down");
    chk("t3_dir", dir_up, 0);
    wait_cmd(2'b11, "t3_serve");
    chk("t3_floor", cur_floor, 0); chk("t3_no_up", saw_up, 0);
    wait_idle("t3_idle");

    // request at current floor: serve with no move; clear beats same-cycle set
    car_auto = 1'b0; cur_floor = 1; do_reset();
    saw_up = 1'b0; saw_dn = 1'b0;
    req(1); tick();
    chk("t4_serve", command, 2'b11); chk("t4_nomove", {saw_up, saw_dn}, 0);
    doors_open = 1'b1; tick();
    req_valid = 1'b1; req_floor = 1; served_pulse = 1'b1; tick();
    chk("t4_clr_wins", pending, 0);
    req(1);  // arrives during DOOR_WAIT, doors still open
    chk("t4_dw_pend", pending, 5'b00010); chk("t4_dw_cmd", command, 0);
    doors_open = 1'b0; tick(); tick();
    chk("t4_reserve", command, 2'b11);
    doors_open = 1'b1; tick(); served_pulse = 1'b1; tick(); doors_open = 1'b0; tick();
    chk("t4_idle", busy, 0);

    // out-of-range request dropped
    req(5);
    chk("t5_pend", pending, 0); tick(); chk("t5_cmd", command, 0);

    // car stuck at floor 0 with a move requested
    cur_floor = '0; do_reset();
    req(3);
    for (int i = 0; i < 30; i++) tick();
`ifdef ELEV_CTRL_WATCHDOG_EN
    chk("t6_fault", fault, 1); chk("t6_cmd", command, 0);
`else
    chk("t6_fault", fault, 0); chk("t6_cmd", command, 2'b01);
`endif
    req(1); tick();
    chk("t6_latch", pending, 5'b01010);
`ifdef ELEV_CTRL_WATCHDOG_EN
    chk("t6_sticky", fault, 1);
`endif
    do_reset(); chk("t6_rst", fault, 0);

    // random traffic with occasional mid-operation resets
    chaos = 1'b1; car_auto = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        req_valid = 1'b0; served_pulse = 1'b0;
        do_reset();
      end else tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
